// File: rtl/pipe_ctrl.sv
// pipe_ctrl: load-use / mult-div hazard control and mult/div busy sequencer.
// Define PIPE_CTRL_PERF_EN to build the saturating stall_cnt counter.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        use_rs_D,
  input  logic        use_rt_D,
  input  logic        load_E,
  input  logic [4:0]  wa_E,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic        md_use_D,
  output logic        stall,
  output logic        flush_E,
  output logic        md_busy,
  output logic        md_done,
  output logic        md_err,
  output logic [15:0] stall_cnt
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  logic       state;
  logic [3:0] md_cnt;
  logic       load_use;
  logic       md_hazard;

  assign md_busy = (state == S_BUSY);
  assign md_done = md_busy && (md_cnt == 4'd1);

  // Hazard decode; both sources merge into a single stall/bubble
  always_comb begin
    load_use  = load_E && (wa_E != 5'd0) &&
                ((use_rs_D && (rs_D == wa_E)) ||
                 (use_rt_D && (rt_D == wa_E)));
    md_hazard = md_use_D && (md_busy || md_start_E);
    stall     = load_use || md_hazard;
    flush_E   = stall;
  end

  // Mult/div occupancy sequencer; starts while busy are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      md_cnt <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (md_start_E) begin
            md_cnt <= md_div_E ? 4'd10 : 4'd5;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          md_cnt <= md_cnt - 4'd1;
          if (md_cnt == 4'd1)
            state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          md_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Sticky error: a start arriving while the unit is occupied
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      md_err <= 1'b0;
    else if (md_start_E && md_busy)
      md_err <= 1'b1;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] cnt_q;

  // Saturating count of stall cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= 16'd0;
    else if (stall && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of hazard decode, mult/div sequencer,
// error flag, async reset abort and (with PIPE_CTRL_PERF_EN) stall_cnt.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_D, rt_D, wa_E;
  logic        use_rs_D, use_rt_D, load_E;
  logic        md_start_E, md_div_E, md_use_D;
  logic        stall, flush_E, md_busy, md_done, md_err;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipe_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .use_rs_D   (use_rs_D),
    .use_rt_D   (use_rt_D),
    .load_E     (load_E),
    .wa_E       (wa_E),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .md_use_D   (md_use_D),
    .stall      (stall),
    .flush_E    (flush_E),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_err     (md_err),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp();
    return PERF ? 16'(exp_cnt) : 16'd0;
  endfunction

  // advance one clock; s is the stall value expected in the ending cycle
  task automatic step(input bit s);
    if (s && exp_cnt < 65535) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs_D = 0; rt_D = 0; wa_E = 0;
    use_rs_D = 0; use_rt_D = 0; load_E = 0;
    md_start_E = 0; md_div_E = 0; md_use_D = 0;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    #12;
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_err", md_err, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b1;
    step(0);

    // load-use on rs
    load_E = 1; wa_E = 8; use_rs_D = 1; rs_D = 8;
    #1;
    chk("lu_rs_stall", stall, 1);
    chk("lu_rs_flush", flush_E, 1);
    chk("lu_rs_cnt0", stall_cnt, 0);
    step(1);
    clr();
    #1;
    chk("lu_rs_clear", stall, 0);
    chk("lu_rs_cnt1", stall_cnt, cnt_exp());

    // r0 destination never hazards
    load_E = 1; wa_E = 0; rs_D = 0; use_rs_D = 1;
    #1;
    chk("lu_r0", stall, 0);
    // rt match, then not-used, then not-a-load
    wa_E = 9; rt_D = 9; use_rt_D = 1; rs_D = 3;
    #1;
    chk("lu_rt", stall, 1);
    use_rt_D = 0;
    #1;
    chk("lu_rt_unused", stall, 0);
    use_rt_D = 1; load_E = 0;
    #1;
    chk("lu_noload", flush_E, 0);
    clr();
    step(0);

    // multiply with md_use_D held: stall cycles 0..5
    md_use_D = 1; md_start_E = 1; md_div_E = 0;
    #1;
    chk("mul_c0_stall", stall, 1);
    chk("mul_c0_busy", md_busy, 0);
    step(1);
    md_start_E = 0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("mul_c%0d_busy", i), md_busy, 1);
      chk($sformatf("mul_c%0d_done", i), md_done, (i == 5));
      chk($sformatf("mul_c%0d_stall", i), stall, 1);
      if (i == 3) begin
        // load-use on top of md hazard still one stall
        load_E = 1; wa_E = 4; use_rs_D = 1; rs_D = 4;
        #1;
        chk("both_stall", stall, 1);
      end
      step(1);
      load_E = 0; use_rs_D = 0;
    end
    chk("mul_c6_busy", md_busy, 0);
    chk("mul_c6_done", md_done, 0);
    chk("mul_c6_stall", stall, 0);
    chk("mul_cnt", stall_cnt, cnt_exp());
    chk("mul_err", md_err, 0);
    clr();
    step(0);

    // divide, restart (as multiply) in busy cycle 4
    md_start_E = 1; md_div_E = 1;
    step(0);
    clr();
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) md_start_E = 1;
      #1;
      chk($sformatf("div_c%0d_busy", i), md_busy, 1);
      chk($sformatf("div_c%0d_done", i), md_done, (i == 10));
      chk($sformatf("div_c%0d_err", i), md_err, (i >= 5));
      step(0);
      md_start_E = 0;
    end
    chk("div_c11_busy", md_busy, 0);
    chk("div_c11_err", md_err, 1);

    // divide aborted by reset in busy cycle 3
    md_start_E = 1; md_div_E = 1;
    step(0);
    clr();
    step(0);
    step(0);
    chk("abort_c3_busy", md_busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", md_busy, 0);
    chk("abort_done", md_done, 0);
    chk("abort_err", md_err, 0);
    chk("abort_cnt", stall_cnt, 0);
    exp_cnt = 0;
    load_E = 1; wa_E = 7; use_rt_D = 1; rt_D = 7;
    #1;
    chk("rst_lu_stall", stall, 1);
    chk("rst_lu_flush", flush_E, 1);
    clr();
    md_use_D = 1;
    #1;
    chk("rst_md_stall", stall, 0);
    clr();
    @(negedge clk);
    reset = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (md_done || md_busy) seen++;
        step(0);
      end
      chk("abort_no_done", 16'(seen), 0);
    end

    // start in the done cycle is treated as busy
    md_start_E = 1;
    step(0);
    clr();
    step(0); step(0); step(0); step(0);
    chk("dn_c5_done", md_done, 1);
    md_start_E = 1; md_div_E = 1;
    step(0);
    clr();
    #1;
    chk("dn_c6_busy", md_busy, 0);
    chk("dn_c6_err", md_err, 1);
    chk("dn_cnt", stall_cnt, cnt_exp());

`ifdef PIPE_CTRL_PERF_EN
    load_E = 1; wa_E = 5; use_rs_D = 1; rs_D = 5;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_cnt", stall_cnt, 16'hFFFF);
    clr();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
